// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the SPI bus arbiter: FSM state encoding,
// chip-select idle value, slave indices and the tgt-to-cs decoder.
package spi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  localparam logic [2:0] CS_IDLE      = 3'b111;
  localparam logic [1:0] SLV_KEYEXP   = 2'd0;
  localparam logic [1:0] SLV_CIPHER   = 2'd1;
  localparam logic [1:0] SLV_DECIPHER = 2'd2;
  localparam int         MAX_LEN      = 256;

  // Active-low one-hot select; the cs bit index equals the slave index.
  function automatic logic [2:0] cs_for_tgt(input logic [1:0] tgt);
    logic [2:0] r;
    r = CS_IDLE;
    case (tgt)
      SLV_KEYEXP:   r = 3'b110;
      SLV_CIPHER:   r = 3'b101;
      SLV_DECIPHER: r = 3'b011;
      default:      r = CS_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1 (with
// wrap) wins; returns one-hot winner, its index, and a valid flag.
module spi_bus_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path can
    // leave one unassigned and infer a latch.
    any_o     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!any_o && req_i[(int'(ptr_i) + off) % NUM_REQ]) begin
        any_o                                     = 1'b1;
        gnt_oh_o[(int'(ptr_i) + off) % NUM_REQ]   = 1'b1;
        gnt_idx_o = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus among NUM_REQ requesters: round-robin grant, cs framing
// (SETUP, len SHIFT bits, GUARD), data muxing, lock chaining and abort.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [2*NUM_REQ-1:0]     tgt,
  input  logic [LEN_W*NUM_REQ-1:0] len,
  input  logic [NUM_REQ-1:0]       mosi_in,
  input  logic                     miso,
  output logic [2:0]               cs,
  output logic                     mosi,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [LEN_W-1:0]         bit_idx,
  output logic [NUM_REQ-1:0]       bit_vld,
  output logic                     miso_out,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [2:0]           cs_q, cs_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic [1:0]           tgt_a [NUM_REQ];
  logic [LEN_W-1:0]     len_a [NUM_REQ];
  logic                 arb_any;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]     arb_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign tgt_a[g] = tgt[2*g +: 2];
    assign len_a[g] = len[LEN_W*g +: LEN_W];
  end

  function automatic logic xfer_ok(input logic [1:0] t, input logic [LEN_W-1:0] n);
    return (t <= SLV_DECIPHER) && (n != '0);
  endfunction

  spi_bus_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .any_o     (arb_any),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          ptr_d = arb_idx;
          if (!xfer_ok(tgt_a[arb_idx], len_a[arb_idx])) begin
            err_d = arb_oh;
          end else begin
            gidx_d  = arb_idx;
            gnt_d   = arb_oh;
            cs_d    = cs_for_tgt(tgt_a[arb_idx]);
            len_d   = len_a[arb_idx];
            cnt_d   = '0;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP, ST_SHIFT: begin
        if (!req[gidx_q]) begin
          // Requester withdrew mid-transfer: release the bus and flag it.
          err_d   = gnt_q;
          gnt_d   = '0;
          cs_d    = CS_IDLE;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (state_q == ST_SETUP) begin
          state_d = ST_SHIFT;
        end else if (cnt_q == len_q - LEN_W'(1)) begin
          done_d  = gnt_q;
          cs_d    = CS_IDLE;
          cnt_d   = '0;
          state_d = ST_GUARD;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        // Locked re-grant skips arbitration; tgt/len are re-sampled here.
        if (lock[gidx_q] && req[gidx_q]) begin
          if (xfer_ok(tgt_a[gidx_q], len_a[gidx_q])) begin
            gnt_d   = gnt_q;
            cs_d    = cs_for_tgt(tgt_a[gidx_q]);
            len_d   = len_a[gidx_q];
            cnt_d   = '0;
            state_d = ST_SETUP;
          end else begin
            err_d = gnt_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      gidx_q  <= '0;
      gnt_q   <= '0;
      cs_q    <= CS_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cs       = cs_q;
  assign gnt      = gnt_q;
  assign bit_idx  = cnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mosi     = (state_q == ST_SHIFT) ? mosi_in[gidx_q] : 1'b0;
  assign bit_vld  = (state_q == ST_SHIFT) ? gnt_q : '0;
  assign miso_out = miso;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a table of single transfers plus
// hand-written contention, lock-chain, abort and mid-transfer reset sequences.
module tb_spi_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int LEN_W   = 9;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [2*NUM_REQ-1:0]     tgt;
  logic [LEN_W*NUM_REQ-1:0] len;
  logic [NUM_REQ-1:0]       mosi_in;
  logic                     miso;
  logic [2:0]               cs;
  logic                     mosi;
  logic [NUM_REQ-1:0]       gnt;
  logic [LEN_W-1:0]         bit_idx;
  logic [NUM_REQ-1:0]       bit_vld;
  logic                     miso_out;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       err;

  int checks = 0;
  int errors = 0;

  spi_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LEN_W   (LEN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .tgt      (tgt),
    .len      (len),
    .mosi_in  (mosi_in),
    .miso     (miso),
    .cs       (cs),
    .mosi     (mosi),
    .gnt      (gnt),
    .bit_idx  (bit_idx),
    .bit_vld  (bit_vld),
    .miso_out (miso_out),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         r;
    logic [1:0] t;
    int         n;
    bit         is_err;
    logic [2:0] exp_cs;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs"},      32'(cs),      32'(3'b111));
    check({tag, "_mosi"},    32'(mosi),    32'(0));
    check({tag, "_gnt"},     32'(gnt),     32'(0));
    check({tag, "_bit_idx"}, 32'(bit_idx), 32'(0));
    check({tag, "_bit_vld"}, 32'(bit_vld), 32'(0));
    check({tag, "_done"},    32'(done),    32'(0));
    check({tag, "_err"},     32'(err),     32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    req     = '0;
    lock    = '0;
    mosi_in = '0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts a transfer from IDLE (or from GUARD when chaining) and checks
  // every cycle: SETUP, n SHIFT bits, GUARD, and the IDLE cycle after unless held.
  task automatic run_xfer(input int r, input logic [1:0] t, input int n,
                          input logic [2:0] exp_cs, input bit hold);
    logic [NUM_REQ-1:0] oh;
    logic               pb;
    oh = '0;
    oh[r] = 1'b1;
    req[r] = 1'b1;
    tgt[2*r +: 2] = t;
    len[LEN_W*r +: LEN_W] = LEN_W'(n);
    mosi_in = '0;
    step();
    check("setup_gnt",  32'(gnt),     32'(oh));
    check("setup_cs",   32'(cs),      32'(exp_cs));
    check("setup_mosi", 32'(mosi),    32'(0));
    check("setup_vld",  32'(bit_vld), 32'(0));
    for (int k = 0; k < n; k++) begin
      step();
      pb = 1'($urandom_range(0, 1));
      mosi_in = {NUM_REQ{~pb}};
      mosi_in[r] = pb;
      miso = 1'($urandom_range(0, 1));
      #1;
      check("shift_idx",  32'(bit_idx),  32'(k));
      check("shift_cs",   32'(cs),       32'(exp_cs));
      check("shift_gnt",  32'(gnt),      32'(oh));
      check("shift_vld",  32'(bit_vld),  32'(oh));
      check("shift_mosi", 32'(mosi),     32'(pb));
      check("shift_miso", 32'(miso_out), 32'(miso));
    end
    step();
    check("guard_done", 32'(done),    32'(oh));
    check("guard_cs",   32'(cs),      32'(3'b111));
    check("guard_gnt",  32'(gnt),     32'(oh));
    check("guard_mosi", 32'(mosi),    32'(0));
    check("guard_vld",  32'(bit_vld), 32'(0));
    check("guard_err",  32'(err),     32'(0));
    if (!hold) begin
      req[r]  = 1'b0;
      lock[r] = 1'b0;
      step();
      check("post_gnt",  32'(gnt),  32'(0));
      check("post_done", 32'(done), 32'(0));
      check("post_cs",   32'(cs),   32'(3'b111));
    end
  endtask

  task automatic run_err(input int r, input logic [1:0] t, input int n);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    req[r] = 1'b1;
    tgt[2*r +: 2] = t;
    len[LEN_W*r +: LEN_W] = LEN_W'(n);
    step();
    check("inv_err",  32'(err),  32'(oh));
    check("inv_gnt",  32'(gnt),  32'(0));
    check("inv_cs",   32'(cs),   32'(3'b111));
    check("inv_done", 32'(done), 32'(0));
    req[r] = 1'b0;
    step();
    check("inv_err_clr", 32'(err), 32'(0));
    check("inv_gnt2",    32'(gnt), 32'(0));
    check("inv_cs2",     32'(cs),  32'(3'b111));
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    lock    = '0;
    tgt     = '0;
    len     = '0;
    mosi_in = '0;
    miso    = 1'b0;

    vecs[0] = '{r: 0, t: 2'd0, n: 1,   is_err: 1'b0, exp_cs: 3'b110};
    vecs[1] = '{r: 1, t: 2'd2, n: 3,   is_err: 1'b0, exp_cs: 3'b011};
    vecs[2] = '{r: 0, t: 2'd3, n: 5,   is_err: 1'b1, exp_cs: 3'b111};
    vecs[3] = '{r: 1, t: 2'd1, n: 0,   is_err: 1'b1, exp_cs: 3'b111};
    vecs[4] = '{r: 0, t: 2'd1, n: 2,   is_err: 1'b0, exp_cs: 3'b101};
    vecs[5] = '{r: 1, t: 2'd0, n: 7,   is_err: 1'b0, exp_cs: 3'b110};

    do_reset();

    // Single maximum-length transfer to the key-expansion slave.
    run_xfer(0, 2'd0, 256, 3'b110, 1'b0);

    // Contention straight after reset: requester 0 first, then 1, twice.
    do_reset();
    req[1] = 1'b1;
    tgt[2 +: 2] = 2'd2;
    len[LEN_W +: LEN_W] = LEN_W'(128);
    run_xfer(0, 2'd1, 128, 3'b101, 1'b0);
    run_xfer(1, 2'd2, 128, 3'b011, 1'b0);
    req[1] = 1'b1;
    run_xfer(0, 2'd1, 128, 3'b101, 1'b0);
    run_xfer(1, 2'd2, 128, 3'b011, 1'b0);

    // Lock chain on requester 1; requester 0 waits until the chain ends.
    lock[1] = 1'b1;
    run_xfer(1, 2'd1, 128, 3'b101, 1'b1);
    req[0] = 1'b1;
    tgt[1:0] = 2'd0;
    len[LEN_W-1:0] = LEN_W'(16);
    run_xfer(1, 2'd2, 128, 3'b011, 1'b0);
    run_xfer(0, 2'd0, 16, 3'b110, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_err) run_err(vecs[i].r, vecs[i].t, vecs[i].n);
      else run_xfer(vecs[i].r, vecs[i].t, vecs[i].n, vecs[i].exp_cs, 1'b0);
    end

    // Abort: requester 0 drops req while bit 40 of 128 is on the bus.
    req[0] = 1'b1;
    tgt[1:0] = 2'd1;
    len[LEN_W-1:0] = LEN_W'(128);
    step();
    check("abort_setup_cs", 32'(cs), 32'(3'b101));
    repeat (41) step();
    check("abort_idx", 32'(bit_idx), 32'(40));
    check("abort_vld", 32'(bit_vld), 32'(2'b01));
    req[0] = 1'b0;
    step();
    check("abort_cs",   32'(cs),      32'(3'b111));
    check("abort_err",  32'(err),     32'(2'b01));
    check("abort_gnt",  32'(gnt),     32'(0));
    check("abort_done", 32'(done),    32'(0));
    check("abort_vld2", 32'(bit_vld), 32'(0));
    step();
    check("abort_err_clr", 32'(err),  32'(0));
    check("abort_no_done", 32'(done), 32'(0));
    check("abort_idle_cs", 32'(cs),   32'(3'b111));

    // Reset at bit 100 with requester 1 pending; 1 is served afterwards.
    req[0] = 1'b1;
    tgt[1:0] = 2'd0;
    len[LEN_W-1:0] = LEN_W'(128);
    step();
    check("rst_setup_gnt", 32'(gnt), 32'(2'b01));
    req[1] = 1'b1;
    tgt[3:2] = 2'd1;
    len[2*LEN_W-1:LEN_W] = LEN_W'(20);
    repeat (101) step();
    check("rst_pre_idx", 32'(bit_idx), 32'(100));
    check("rst_pre_cs",  32'(cs),      32'(3'b110));
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_cs",  32'(cs),      32'(3'b111));
    check("rst_mid_gnt", 32'(gnt),     32'(0));
    check("rst_mid_vld", 32'(bit_vld), 32'(0));
    check("rst_mid_idx", 32'(bit_idx), 32'(0));
    req[0] = 1'b0;
    #2;
    reset = 1'b0;
    run_xfer(1, 2'd1, 20, 3'b101, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
Shares one SPI bus (cs[2:0] active-low, mosi, miso) among NUM_REQ requesters, e.g. the key-load/encrypt host path and the decrypt host path feeding the key-expansion, cipher and decipher slaves.
- Arbitrates round-robin between requesters.
- Frames each transfer: asserts cs, counts bits, then a guard cycle.
- Muxes the granted requester's serial data onto mosi and routes miso back to it.
- A lock input keeps the bus across back-to-back transfers, e.g. send block, then read result.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
LEN_W, 9, width of per-requester bit-count field (max 256 bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  transfer request per requester; must hold until done/err
lock  in  NUM_REQ  keep grant after this transfer if req still high
tgt  in  2*NUM_REQ  slave index per requester (0,1,2 valid; 3 invalid)
len  in  LEN_W*NUM_REQ  bits to transfer per requester (1..256 valid)
mosi_in  in  NUM_REQ  serial data from each requester
miso  in  1  shared SPI input
cs  out  3  active-low slave selects, one-hot-low when active
mosi  out  1  shared SPI output
gnt  out  NUM_REQ  one-hot grant
bit_idx  out  LEN_W  index of the current bit during SHIFT
bit_vld  out  NUM_REQ  per-requester strobe: miso valid this cycle
miso_out  out  1  miso copy (qualify with bit_vld)
done  out  NUM_REQ  one-cycle completion pulse
err  out  NUM_REQ  one-cycle error pulse

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - cs=3'b111, mosi=0, gnt=0, bit_idx=0, bit_vld=0, done=0, err=0.
  - State=IDLE, round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, SETUP, SHIFT, GUARD.
- IDLE:
  - If any req, choose the winner: first requester with req high, searching from pointer+1 with wrap.
  - Winner with tgt==3 or len==0: err[winner] pulse next cycle, no grant, pointer updated, stay IDLE.
  - Otherwise, next cycle: gnt[winner]=1, cs[tgt]=0, state=SETUP, pointer=winner, bit_idx=0.
- SETUP (1 cycle): cs held low, mosi=0. Next state is SHIFT.
- SHIFT (exactly len cycles):
  - mosi = mosi_in[granted], combinational mux gated by state; mosi=0 outside SHIFT.
  - bit_vld[granted]=1 each cycle; miso_out=miso.
  - bit_idx increments 0..len-1; len is sampled at grant and stays stable for the transfer.
  - After the cycle with bit_idx==len-1, go to GUARD.
- GUARD (1 cycle): cs=3'b111, done[granted] pulse.
  - If lock[granted] and req[granted] are high in this cycle: re-grant the same requester next cycle (SETUP, fresh tgt/len sampled), no arbitration.
  - Otherwise gnt=0 and return to IDLE.
- Minimum cost is len+3 cycles per unlocked transfer (IDLE→SETUP→SHIFT×len→GUARD) and len+2 per locked follow-on.
- Abort: if req[granted] drops during SETUP or SHIFT:
  - Next cycle cs=3'b111, err[granted] pulse, no done, gnt=0, state=IDLE.
- Simultaneous requests: exactly one grant; the pointer guarantees a requester waits at most NUM_REQ-1 transfers (excluding lock chains).
- Requests from non-granted requesters during a transfer are ignored until IDLE; they are not latched.
- tgt/len changes while granted have no effect until the next grant.
- Never more than one cs bit low; cs is never low outside SETUP/SHIFT.

Decomposition:
- Shared package:
  - State encoding (IDLE=0, SETUP=1, SHIFT=2, GUARD=3).
  - CS_IDLE=3'b111.
  - Slave index constants: SLV_KEYEXP=0, SLV_CIPHER=1, SLV_DECIPHER=2; each maps to cs bit index = tgt.
  - MAX_LEN=256.
- Sub-module rr_arbiter: combinational round-robin pick from req and pointer, returns one-hot winner and its index.

Test Plan:
- Single transfer: req0=1, tgt0=0, len0=256, mosi_in0 = pattern.
  - cs=3'b110 for 257 cycles (SETUP+256).
  - mosi matches the pattern bit-for-bit.
  - done0 pulses once on the GUARD cycle; cs returns to 3'b111.
- Contention: req0 and req1 asserted same cycle after reset (tgt0=1, tgt1=2, len=128).
  - Order: req0 first (cs=3'b101), then req1 (cs=3'b011).
  - A second simultaneous pair is served req0 then req1 again: after req1's transfer the pointer sits at 1, so req0 wins.
- Lock chain: req1, lock1=1, tgt1=1, len1=128.
  - After done1, tgt1 is changed to 2 with req0 also high; req1 is re-granted without IDLE.
  - Second transfer uses cs=3'b011; req0 is granted only after lock1 drops.
- Invalid: tgt0=3 or len0=0.
  - err0 pulse, no cs activity, gnt stays 0.
- Abort: req0 drops at bit_idx=40 of 128.
  - cs=3'b111 next cycle, err0 pulse, no done0, state returns to IDLE.
- Reset at bit_idx=100: cs=3'b111, gnt=0, bit_vld=0 immediately.
  - After reset release, pending req1 is granted with bit_idx starting at 0.
